// File: rtl/current_adc_reader.sv
// Pmod AD1 (AD7476) current-sense reader: timed SPI conversions,
// 2^AVG_LOG2-sample averaging, mA scaling with saturation.
module current_adc_reader #(
  parameter int CLK_DIV_HALF  = 4,
  parameter int SAMPLE_PERIOD = 100000,
  parameter int AVG_LOG2      = 3,
  parameter int SCALE_NUM     = 825,
  parameter int SCALE_SHIFT   = 10,
  parameter int MAX_MA        = 999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sdata,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] adc_raw,
  output logic [15:0] current_num,
  output logic        current_valid,
  output logic        overrun
);

  localparam int TW   = $clog2(SAMPLE_PERIOD);
  localparam int DW   = $clog2(2 * CLK_DIV_HALF);
  localparam int ACCW = 12 + AVG_LOG2;
  localparam int CW   = AVG_LOG2 + 1;
  localparam int PW   = 12 + $clog2(SCALE_NUM + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_TC    = DW'(CLK_DIV_HALF - 1);
  localparam logic [DW-1:0] QUIET_TC  = DW'(2 * CLK_DIV_HALF - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_QUIET,
    S_ACCUM,
    S_SCALE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_tick_cnt;
  logic [DW-1:0]   r_div;
  logic [4:0]      r_bits;
  logic [11:0]     r_shift;
  logic [1:0]      r_sync;
  logic [ACCW-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_cs_n;
  logic            r_sclk;
  logic [11:0]     r_raw;
  logic [15:0]     r_num;
  logic            r_valid;
  logic            r_ovr;

  logic            w_tick;
  logic            w_div_tc;
  logic            w_quiet_done;
  logic            w_rise;
  logic            w_last_bit;
  logic            w_cs_n_nxt;
  logic            w_sclk_nxt;
  logic            w_valid_nxt;
  logic [11:0]     w_avg;
  logic [PW-1:0]   w_prod;
  logic [PW-1:0]   w_ma;
  logic [15:0]     w_num_sat;

  assign w_tick       = (r_tick_cnt == TICK_LAST);
  assign w_div_tc     = (r_div == DIV_TC);
  assign w_quiet_done = (r_div == QUIET_TC);
  assign w_rise       = (r_state == S_SHIFT) && w_div_tc && !r_sclk;
  assign w_last_bit   = (r_bits == 5'd15);

  assign w_avg     = r_acc[ACCW-1:AVG_LOG2];
  assign w_prod    = PW'(w_avg) * PW'(SCALE_NUM);
  assign w_ma      = w_prod >> SCALE_SHIFT;
  assign w_num_sat = (w_ma > PW'(MAX_MA)) ? 16'(MAX_MA)
                                          : 16'(w_ma);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_tick && enable) w_next = S_SETUP;
      S_SETUP: if (w_div_tc) w_next = S_SHIFT;
      S_SHIFT: if (w_rise && w_last_bit) w_next = S_QUIET;
      S_QUIET: if (w_quiet_done) w_next = S_ACCUM;
      S_ACCUM: w_next = (r_cnt == CNT_LAST) ? S_SCALE : S_IDLE;
      S_SCALE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pin outputs are decoded from the next state so they leave a flop.
  always_comb begin
    w_cs_n_nxt  = 1'b1;
    w_sclk_nxt  = 1'b1;
    w_valid_nxt = 1'b0;
    if (w_next == S_SETUP || w_next == S_SHIFT)
      w_cs_n_nxt = 1'b0;
    if (r_state == S_SHIFT)
      w_sclk_nxt = w_div_tc ? ~r_sclk : r_sclk;
    if (r_state == S_SCALE)
      w_valid_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_div      <= '0;
      r_bits     <= '0;
      r_shift    <= '0;
      r_sync     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_cs_n     <= 1'b1;
      r_sclk     <= 1'b1;
      r_raw      <= '0;
      r_num      <= '0;
      r_valid    <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_sync     <= {r_sync[0], sdata};
      r_cs_n     <= w_cs_n_nxt;
      r_sclk     <= w_sclk_nxt;
      r_valid    <= w_valid_nxt;

      if (w_tick && r_state != S_IDLE)
        r_ovr <= 1'b1;

      if (r_state != w_next || (r_state == S_SHIFT && w_div_tc))
        r_div <= '0;
      else if (r_state == S_SETUP || r_state == S_SHIFT ||
               r_state == S_QUIET)
        r_div <= r_div + 1'b1;
      else
        r_div <= '0;

      if (r_state == S_IDLE)
        r_bits <= '0;
      else if (w_rise)
        r_bits <= r_bits + 1'b1;

      // Only the low 12 bits survive 16 shifts; leading bits fall off.
      if (w_rise)
        r_shift <= {r_shift[10:0], r_sync[1]};

      if (r_state == S_ACCUM) begin
        r_raw <= r_shift;
        r_acc <= r_acc + ACCW'(r_shift);
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == S_SCALE) begin
        r_num <= w_num_sat;
        r_acc <= '0;
        r_cnt <= '0;
      end
    end
  end

  assign adc_cs_n      = r_cs_n;
  assign adc_sclk      = r_sclk;
  assign adc_raw       = r_raw;
  assign current_num   = r_num;
  assign current_valid = r_valid;
  assign overrun       = r_ovr;

endmodule

// File: tb/tb_current_adc_reader.sv
// Directed bench for current_adc_reader: AD7476 model, vector
// table of conversions, reset/enable/overrun sequences.
module tb_current_adc_reader;

  localparam int CDH = 4;
  localparam int SP  = 200;
  localparam int SP2 = 120;

  logic        clk = 1'b0;
  logic        rst_n, enable, sdata;
  logic        adc_cs_n, adc_sclk, current_valid, overrun;
  logic [11:0] adc_raw;
  logic [15:0] current_num;

  logic        rst2_n, en2, sdata2;
  logic        cs2_n, sclk2, valid2, ov2;
  logic [11:0] raw2;
  logic [15:0] num2;

  always #5 clk = ~clk;

  current_adc_reader #(
    .CLK_DIV_HALF (CDH),
    .SAMPLE_PERIOD(SP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sdata        (sdata),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .adc_raw      (adc_raw),
    .current_num  (current_num),
    .current_valid(current_valid),
    .overrun      (overrun)
  );

  current_adc_reader #(
    .CLK_DIV_HALF (CDH),
    .SAMPLE_PERIOD(SP2)
  ) dut2 (
    .clk          (clk),
    .rst_n        (rst2_n),
    .enable       (en2),
    .sdata        (sdata2),
    .adc_cs_n     (cs2_n),
    .adc_sclk     (sclk2),
    .adc_raw      (raw2),
    .current_num  (num2),
    .current_valid(valid2),
    .overrun      (ov2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, got, got, exp, exp);
    end
  endtask

  // ADC model: bit 15-k appears one clk after the k-th SCLK fall.
  logic [15:0] model_word = 16'h0000;
  initial begin
    int bitidx;
    bitidx = 0;
    sdata  = 1'b0;
    sdata2 = 1'b0;
    forever begin
      @(negedge adc_sclk or negedge adc_cs_n);
      if (adc_sclk === 1'b1) begin
        bitidx = 0;
      end else if (adc_cs_n === 1'b0) begin
        @(posedge clk);
        #1;
        if (bitidx < 16) sdata = model_word[15-bitidx];
        bitidx++;
      end
    end
  end

  typedef struct {
    logic [15:0] word;
    logic [11:0] raw;
    bit          last;
    logic [15:0] ma;
    bit          pause;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v, input int idx);
    int   n, lowc, rises, vcnt, vlat;
    logic prev;
    logic [15:0] ma;
    model_word = v.word;
    n = 0;
    while (adc_cs_n === 1'b1 && n < 3 * SP) begin
      @(posedge clk); #1; n++;
    end
    if (adc_cs_n !== 1'b0) begin
      chk($sformatf("cs_fall_timeout[%0d]", idx), 32'(adc_cs_n), 0);
      return;
    end
    if (v.pause) enable = 1'b0;
    lowc  = 0;
    rises = 0;
    prev  = adc_sclk;
    while (adc_cs_n === 1'b0 && lowc < 40 * CDH) begin
      @(posedge clk); #1; lowc++;
      if (adc_sclk === 1'b1 && prev === 1'b0) rises++;
      prev = adc_sclk;
    end
    chk($sformatf("cs_low_width[%0d]", idx), lowc, 33 * CDH);
    chk($sformatf("sclk_rises[%0d]", idx), rises, 16);
    vcnt = 0;
    vlat = 0;
    ma   = '0;
    for (int c = 1; c <= 3 * CDH + 4; c++) begin
      @(posedge clk); #1;
      if (current_valid === 1'b1) begin
        vcnt++;
        if (vlat == 0) begin
          vlat = c;
          ma   = current_num;
        end
      end
    end
    chk($sformatf("adc_raw[%0d]", idx), 32'(adc_raw), 32'(v.raw));
    chk($sformatf("valid_pulses[%0d]", idx), vcnt, v.last ? 1 : 0);
    if (v.last) begin
      chk($sformatf("valid_latency[%0d]", idx), vlat, 2 * CDH + 2);
      chk($sformatf("current_num[%0d]", idx), 32'(ma), 32'(v.ma));
    end
    if (v.pause) begin
      n = 0;
      for (int c = 0; c < 3 * SP; c++) begin
        @(posedge clk); #1;
        if (adc_cs_n !== 1'b1 || current_valid !== 1'b0) n++;
      end
      chk($sformatf("disabled_activity[%0d]", idx), n, 0);
      chk($sformatf("held_num[%0d]", idx),
          32'(current_num), 32'(v.ma));
      enable = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 8; i++)
      vecs.push_back('{16'h0400, 12'h400, i == 7, 16'd825, 1'b0});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{(i < 4) ? 16'd100 : 16'd108,
                       (i < 4) ? 12'd100 : 12'd108,
                       i == 7, 16'd83, 1'b0});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{16'h0FFF, 12'hFFF, i == 7, 16'd999, 1'b0});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{16'h0000, 12'h000, i == 7, 16'd0, 1'b0});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{16'hF400, 12'h400, i == 7, 16'd825, 1'b0});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{16'd200, 12'd200, 1'b0, 16'd825, i == 3});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{16'd300, 12'd300, i == 3, 16'd201, 1'b0});

    rst_n  = 1'b0;
    rst2_n = 1'b0;
    enable = 1'b0;
    en2    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(adc_cs_n), 1);
    chk("rst_sclk", 32'(adc_sclk), 1);
    chk("rst_raw", 32'(adc_raw), 0);
    chk("rst_num", 32'(current_num), 0);
    chk("rst_valid", 32'(current_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_overrun2", 32'(ov2), 0);

    @(negedge clk);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    enable = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    chk("no_overrun_main", 32'(overrun), 0);
    chk("overrun2_set", 32'(ov2), 1);
    en2 = 1'b0;
    repeat (4 * SP2) @(posedge clk);
    #1;
    chk("overrun2_sticky", 32'(ov2), 1);
    chk("cs2_idle", 32'(cs2_n), 1);
    rst2_n = 1'b0;
    #1;
    chk("overrun2_reset", 32'(ov2), 0);

    // Reset in the middle of a shift window.
    model_word = 16'h0200;
    n = 0;
    while (adc_cs_n === 1'b1 && n < 3 * SP) begin
      @(posedge clk); #1; n++;
    end
    chk("mid_cs_low", 32'(adc_cs_n), 0);
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", 32'(adc_cs_n), 1);
    chk("mid_rst_sclk", 32'(adc_sclk), 1);
    chk("mid_rst_num", 32'(current_num), 0);
    chk("mid_rst_valid", 32'(current_valid), 0);
    chk("mid_rst_raw", 32'(adc_raw), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (adc_cs_n === 1'b1 && n < 2 * SP) begin
      @(posedge clk); #1; n++;
    end
    chk("first_cs_after_reset", n, SP);
    for (int i = 0; i < 8; i++)
      run_vec('{16'h0200, 12'h200, i == 7, 16'd412, 1'b0}, 100 + i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
